// File: rtl/decoder_pipe.sv
// rtl/decoder_pipe.sv - registered binary-to-one-hot/thermometer/one-cold decoder
// with valid/ready handshake, out-of-range flag and accepted-decode counter.
module decoder_pipe #(
  parameter int N_W   = 3,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_W-1:0]   N,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             err,
  output logic [CNT_W-1:0] cnt
);

  // One extra bit so OUT_W == 2**N_W is representable in the range compare.
  localparam int IDX_W = N_W + 1;

  logic [IDX_W-1:0] idx;
  logic             range_err;
  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] thermo;
  logic [OUT_W-1:0] dec_word;
  logic             in_fire;
  logic             out_fire;

  assign idx       = {1'b0, N};
  assign range_err = (idx >= IDX_W'(OUT_W));

  always_comb begin
    onehot = '0;
    thermo = '0;
    for (int i = 0; i < OUT_W; i++) begin
      onehot[i] = (idx == IDX_W'(i));
      thermo[i] = (idx >= IDX_W'(i));
    end
  end

  // Out of range: onehot is already zero, so one-cold naturally yields all ones;
  // the thermometer must be forced to zero explicitly.
  always_comb begin
    dec_word = onehot;
    case (mode)
      2'd1:    dec_word = range_err ? '0 : thermo;
      2'd2:    dec_word = ~onehot;
      default: dec_word = onehot;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      if (in_fire) begin
        out_valid <= 1'b1;
        out       <= dec_word;
        err       <= range_err;
        cnt       <= cnt + CNT_W'(1);
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Parametrised, registered successor to the combinational 3-to-8 decoder: it converts a binary index into a one-hot, one-cold or thermometer code, with a valid/ready handshake on both sides and a single output pipeline register. It adds out-of-range detection and a running decode counter. It sits between an index producer (e.g. an address or select generator) and consumers of select lines that may stall.

## Interface
- N_W, 3, width of the binary index input
- OUT_W, 8, width of the decoded output; legal range 1..2**N_W
- CNT_W, 16, width of the accepted-decode counter
- clk  input  1  clock; all logic on the rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- in_valid  input  1  index/mode valid
- in_ready  output  1  block can accept this cycle
- N  input  N_W  binary index
- mode  input  2  encoding: 0 one-hot, 1 thermometer, 2 one-cold, 3 reserved (treated as 0)
- out_valid  output  1  out/err valid
- out_ready  input  1  consumer accepts
- out  output  OUT_W  decoded word
- err  output  1  index was out of range (N >= OUT_W)
- cnt  output  CNT_W  number of input transfers accepted since reset

## Operation
- Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready on a rising edge.
- in_ready = !out_valid || out_ready. This is combinational and gives full throughput, one decode per cycle, with no bubbles under continuous ready.
- On an input transfer the output register loads (out, err) from the N and mode values present in that cycle. The mode is per-transaction; no state carries over between transactions.
- Encodings for an in-range N (N < OUT_W):
  - Mode 0: out bit N = 1, all other bits 0.
  - Mode 1: out bits 0..N = 1, all other bits 0. Example: N=3, OUT_W=8 gives 00001111.
  - Mode 2: bitwise inverse of mode 0.
  - Mode 3: identical to mode 0. err is not set for mode 3.
- Out of range (N >= OUT_W, possible only when OUT_W < 2**N_W):
  - err = 1.
  - out = all zeros in modes 0, 1 and 3.
  - out = all ones in mode 2.
- out_valid after a clock edge:
  - Set to 1 if an input transfer occurred.
  - Otherwise cleared to 0 if an output transfer occurred.
  - Otherwise held.
- Simultaneous input and output transfer: the new word replaces the old one and out_valid stays 1.
- Stall (out_valid=1, out_ready=0): out, err and out_valid hold stable, and in_ready=0.
- cnt increments by 1 on every input transfer. It wraps from 2**CNT_W-1 to 0 with no flag. cnt is not affected by output transfers.

## Timing
- Reset (rst_n=0 at an edge): out_valid=0, out=0, err=0, cnt=0.
  - in_ready follows its combinational rule, so it is 1 while out_valid=0, including during reset.
  - Inputs presented during a reset cycle are discarded and not counted.
- Reset mid-operation: a pending output word is dropped. Both the output register and the counter clear on that same edge.
- Latency: an input accepted at edge k produces out_valid=1 with the matching out/err after edge k. The word is visible in the cycle after acceptance.
- out, err and cnt are registered outputs. in_ready is combinational from out_valid and out_ready only, with no path from in_valid.
- While out_valid=0, out and err keep their last values. They are don't-care to consumers.

## Test plan
- Reset then sweep: N=0..7, mode=0, in_valid=1, out_ready=1 every cycle -> out=00000001, 00000010, … 10000000 on consecutive cycles one cycle after each input; cnt=8 at the end; err=0 throughout.
- Modes: N=5 with mode=1, then mode=2, then mode=3 -> out=00111111, then 11011111, then 00100000.
- Backpressure: hold out_ready=0 for 4 cycles after accepting N=2 while in_valid=1 with N=6 -> out=00000100 stays stable and in_ready=0. Release out_ready -> the next word is 01000000, cnt=2, no transaction lost or duplicated.
- Out of range, with N_W=3 and OUT_W=5: N=6 in mode 0 -> out=00000, err=1. N=6 in mode 2 -> out=11111, err=1. N=4 in mode 1 -> out=11111, err=0.
- Reset mid-stall: a word is pending with out_ready=0; assert rst_n=0 for one edge -> out_valid=0, out=0, err=0, cnt=0, in_ready=1 on the next cycle.
- Counter wrap, with CNT_W=3: perform 9 input transfers -> cnt reads 1, and the outputs remain correct.
